// File: rtl/uart_des_pkg.sv
// Shared constants and issue-state encoding for the RS232 -> DES receive path.
// Optional checksum byte per block: define UART_RX_CHECKSUM_EN.
package uart_des_pkg;

   localparam int BYTES_PER_BLOCK    = 8;
   localparam int BYTE_W             = 8;
   localparam int BLOCK_W            = BYTES_PER_BLOCK * BYTE_W;
   localparam int DEF_TIMEOUT_CYCLES = 55552;
   localparam int TIMER_W            = 17;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      ISSUE
   } issueState_t;

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Inter-byte idle counter with enable, clear and a single-cycle expire strobe.
// Expire is asserted on the cycle the count sits at LIMIT-1 while enabled.
module uart_rx_idle_timer
   import uart_des_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

   logic [TIMER_W-1:0] count;

   assign expire = enable && !clear && (count == LAST);

   // Count idle cycles; wrap to zero on clear or when the limit is reached.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else if (clear || expire) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TIMER_W'(1);
      end
   end

endmodule

// File: rtl/uart_des_block_assembler.sv
// Packs received bytes LSB-first into 64-bit blocks and issues them to DES.
// Define UART_RX_CHECKSUM_EN for a trailing XOR checksum byte per block.
module uart_des_block_assembler
   import uart_des_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [BYTE_W-1:0]  RecvData,
   input  logic               RecvDataReady,
   input  logic               DES_BUSY,
   output logic               CHIP_SELECT_BAR,
   output logic [BLOCK_W-1:0] PLAIN_TEXT,
   output logic [3:0]         BYTE_CNT,
   output logic               RecvLED,
   output logic               TIMEOUT_ERR,
   output logic               OVERRUN_ERR,
   output logic               CHECKSUM_ERR
);

`ifdef UART_RX_CHECKSUM_EN
   localparam logic [3:0] LAST_LANE = 4'(BYTES_PER_BLOCK);
`else
   localparam logic [3:0] LAST_LANE = 4'(BYTES_PER_BLOCK - 1);
`endif

   issueState_t        state;
   logic [BLOCK_W-1:0] asmReg;
   logic [BLOCK_W-1:0] asmNext;
   logic [3:0]         cntNext;
   logic               pendNext;
   logic               complete;
   logic               sumOk;
   logic               load;
   logic               overrun;
   logic               expire;
   logic               timerEn;
   logic               timerClr;

   assign complete = RecvDataReady && (BYTE_CNT == LAST_LANE);
   assign load     = complete && sumOk && (state == IDLE);
   assign overrun  = complete && sumOk && (state != IDLE);
   assign timerEn  = (BYTE_CNT != 4'd0) && !RecvDataReady;
   assign timerClr = RecvDataReady || (BYTE_CNT == 4'd0);

   uart_rx_idle_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) idleTimer (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .enable (timerEn),
      .clear  (timerClr),
      .expire (expire)
   );

`ifdef UART_RX_CHECKSUM_EN
   logic [BYTE_W-1:0] xorReg;

   assign sumOk = (RecvData == xorReg);

   // Running XOR of payload bytes, restarted whenever the block restarts.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         xorReg       <= '0;
         CHECKSUM_ERR <= 1'b0;
      end else begin
         CHECKSUM_ERR <= complete && !sumOk;
         if (complete || expire) begin
            xorReg <= '0;
         end else if (RecvDataReady) begin
            xorReg <= xorReg ^ RecvData;
         end
      end
   end
`else
   assign sumOk        = 1'b1;
   assign CHECKSUM_ERR = 1'b0;
`endif

   // Write the incoming byte into its lane; the checksum byte has no lane.
   always_comb begin
      asmNext = asmReg;
      if (RecvDataReady && !BYTE_CNT[3]) begin
         asmNext[{BYTE_CNT[2:0], 3'b000} +: BYTE_W] = RecvData;
      end
   end

   // Next byte count and pending flag, shared by the counter and the LED.
   always_comb begin
      cntNext = BYTE_CNT;
      if (RecvDataReady) begin
         cntNext = complete ? 4'd0 : BYTE_CNT + 4'd1;
      end else if (expire) begin
         cntNext = 4'd0;
      end
      pendNext = load || ((state == PENDING) && DES_BUSY);
   end

   // Byte collection, status LED and error strobes.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         asmReg      <= '0;
         BYTE_CNT    <= 4'd0;
         RecvLED     <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         OVERRUN_ERR <= 1'b0;
      end else begin
         asmReg      <= asmNext;
         BYTE_CNT    <= cntNext;
         RecvLED     <= (cntNext != 4'd0) || pendNext;
         TIMEOUT_ERR <= expire;
         OVERRUN_ERR <= overrun;
      end
   end

   // Hold a completed block until DES is free, then pulse chip select.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state           <= IDLE;
         CHIP_SELECT_BAR <= 1'b0;
         PLAIN_TEXT      <= '0;
      end else begin
         CHIP_SELECT_BAR <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load) begin
                  state      <= PENDING;
                  PLAIN_TEXT <= asmNext;
               end
            end
            PENDING: begin
               if (!DES_BUSY) begin
                  state           <= ISSUE;
                  CHIP_SELECT_BAR <= 1'b1;
               end
            end
            ISSUE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_des_block_assembler.sv
// Self-checking bench: directed vector table, corner sequences, and
// randomized traffic against a queue-based block model.
module tb_uart_des_block_assembler;

   localparam int TO = 40;
`ifdef UART_RX_CHECKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [7:0]  RecvData = 8'h00;
   logic        RecvDataReady = 1'b0;
   logic        DES_BUSY = 1'b0;
   logic        CHIP_SELECT_BAR;
   logic [63:0] PLAIN_TEXT;
   logic [3:0]  BYTE_CNT;
   logic        RecvLED;
   logic        TIMEOUT_ERR;
   logic        OVERRUN_ERR;
   logic        CHECKSUM_ERR;

   int nRun = 0;
   int nFail = 0;

   always #5 CLK = ~CLK;

   uart_des_block_assembler #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK             (CLK),
      .RST_N           (RST_N),
      .RecvData        (RecvData),
      .RecvDataReady   (RecvDataReady),
      .DES_BUSY        (DES_BUSY),
      .CHIP_SELECT_BAR (CHIP_SELECT_BAR),
      .PLAIN_TEXT      (PLAIN_TEXT),
      .BYTE_CNT        (BYTE_CNT),
      .RecvLED         (RecvLED),
      .TIMEOUT_ERR     (TIMEOUT_ERR),
      .OVERRUN_ERR     (OVERRUN_ERR),
      .CHECKSUM_ERR    (CHECKSUM_ERR)
   );

   typedef struct {
      bit          rdy;
      logic [7:0]  d;
      logic        csb;
      logic [63:0] pt;
      logic [3:0]  cnt;
      logic        led;
   } vec_t;

   vec_t tbl[$];

   // reference model state
   logic [7:0]  part[$];
   int          idle;
   bit          mPend;
   bit          mCsb;
   logic [63:0] mPt;
   bit          eTo;
   bit          eOv;
   bit          eCs;

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      nRun++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit rdy, input logic [7:0] d, input bit busy);
      RecvDataReady = rdy;
      RecvData = d;
      DES_BUSY = busy;
      @(posedge CLK);
      #1;
      RecvDataReady = 1'b0;
   endtask

   task automatic doReset();
      RST_N = 1'b0;
      RecvDataReady = 1'b0;
      DES_BUSY = 1'b0;
      repeat (2) @(posedge CLK);
      #3;
      RST_N = 1'b1;
   endtask

   task automatic sendBlock(input logic [63:0] blk, input bit busy,
                            input bit goodSum);
      logic [7:0] s;
      s = 8'h00;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, blk[8*k +: 8], busy);
         s ^= blk[8*k +: 8];
      end
      if (!goodSum) s = ~s;
`ifdef UART_RX_CHECKSUM_EN
      cyc(1'b1, s, busy);
`endif
   endtask

   function automatic logic [79:0] outs();
      return {7'd0, CHIP_SELECT_BAR, PLAIN_TEXT, BYTE_CNT, RecvLED,
              TIMEOUT_ERR, OVERRUN_ERR, CHECKSUM_ERR};
   endfunction

   function automatic logic [79:0] modelOuts();
      logic led;
      led = (part.size() != 0) || mPend;
      return {7'd0, mCsb, mPt, 4'(part.size()), led, eTo, eOv, eCs};
   endfunction

   task automatic modelReset();
      part.delete();
      idle = 0;
      mPend = 1'b0;
      mCsb = 1'b0;
      mPt = 64'h0;
      eTo = 1'b0;
      eOv = 1'b0;
      eCs = 1'b0;
   endtask

   // One clock edge of the block-level behaviour, from pre-edge state.
   task automatic modelStep(input bit rdy, input logic [7:0] d, input bit busy);
      bit wasPend;
      bit wasCsb;
      bit ok;
      logic [63:0] blk;
      logic [7:0] s;
      wasPend = mPend;
      wasCsb = mCsb;
      eTo = 1'b0;
      eOv = 1'b0;
      eCs = 1'b0;
      mCsb = 1'b0;
      if (wasPend && !busy) begin
         mCsb = 1'b1;
         mPend = 1'b0;
      end
      if (rdy) begin
         part.push_back(d);
         idle = 0;
         if (part.size() == NB) begin
            blk = 64'h0;
            s = 8'h00;
            for (int k = 0; k < 8; k++) begin
               blk[8*k +: 8] = part[k];
               s ^= part[k];
            end
            ok = (NB == 8) || (part[NB-1] == s);
            part.delete();
            if (!ok) eCs = 1'b1;
            else if (!wasPend && !wasCsb) begin
               mPt = blk;
               mPend = 1'b1;
            end else eOv = 1'b1;
         end
      end else if (part.size() != 0) begin
         idle++;
         if (idle == TO) begin
            part.delete();
            idle = 0;
            eTo = 1'b1;
         end
      end
   endtask

   initial begin
      vec_t v;
      int pr;
      int pb;
      bit r;
      bit b;
      logic [7:0] d;

      // ---- vector table: basic block 0x01..0x08 ----
      for (int k = 0; k < NB; k++) begin
         v.rdy = 1'b1;
         v.d = (k < 8) ? 8'(k + 1) : 8'h08;
         v.csb = 1'b0;
         v.led = 1'b1;
         v.cnt = (k == NB - 1) ? 4'd0 : 4'(k + 1);
         v.pt = (k == NB - 1) ? 64'h0807060504030201 : 64'h0;
         tbl.push_back(v);
      end
      v.rdy = 1'b0;
      v.d = 8'h00;
      v.csb = 1'b1;
      v.led = 1'b0;
      v.cnt = 4'd0;
      v.pt = 64'h0807060504030201;
      tbl.push_back(v);
      v.csb = 1'b0;
      tbl.push_back(v);
      tbl.push_back(v);

      doReset();
      chk("reset outs", outs(), 80'h0);
      foreach (tbl[i]) begin
         cyc(tbl[i].rdy, tbl[i].d, 1'b0);
         chk("vec csb", 80'(CHIP_SELECT_BAR), 80'(tbl[i].csb));
         chk("vec pt", 80'(PLAIN_TEXT), 80'(tbl[i].pt));
         chk("vec cnt", 80'(BYTE_CNT), 80'(tbl[i].cnt));
         chk("vec led", 80'(RecvLED), 80'(tbl[i].led));
         chk("vec errs", 80'({TIMEOUT_ERR, OVERRUN_ERR, CHECKSUM_ERR}), 80'h0);
      end

      // ---- timeout after 3 bytes, then a fresh block ----
      doReset();
      for (int k = 0; k < 3; k++) cyc(1'b1, 8'h30 + 8'(k), 1'b0);
      for (int k = 0; k < TO - 1; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         chk("to early", 80'({TIMEOUT_ERR, BYTE_CNT}), 80'({1'b0, 4'd3}));
      end
      cyc(1'b0, 8'h00, 1'b0);
      chk("to pulse", 80'({TIMEOUT_ERR, BYTE_CNT, RecvLED}), 80'({1'b1, 4'd0, 1'b0}));
      cyc(1'b0, 8'h00, 1'b0);
      chk("to one cycle", 80'(TIMEOUT_ERR), 80'h0);
      sendBlock(64'hA7A6A5A4A3A2A1A0, 1'b0, 1'b1);
      chk("after to pt", 80'(PLAIN_TEXT), 80'(64'hA7A6A5A4A3A2A1A0));
      cyc(1'b0, 8'h00, 1'b0);
      chk("after to csb", 80'(CHIP_SELECT_BAR), 80'h1);

      // ---- back-pressure and overrun ----
      doReset();
      sendBlock(64'h1111111111111111, 1'b1, 1'b1);
      chk("busy pt", 80'(PLAIN_TEXT), 80'(64'h1111111111111111));
      chk("busy led", 80'(RecvLED), 80'h1);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 8'h00, 1'b1);
         chk("busy no csb", 80'(CHIP_SELECT_BAR), 80'h0);
      end
      sendBlock(64'h2222222222222222, 1'b1, 1'b1);
      chk("overrun pulse", 80'({OVERRUN_ERR, BYTE_CNT}), 80'({1'b1, 4'd0}));
      chk("overrun pt", 80'(PLAIN_TEXT), 80'(64'h1111111111111111));
      cyc(1'b0, 8'h00, 1'b1);
      chk("overrun one cycle", 80'({OVERRUN_ERR, CHIP_SELECT_BAR}), 80'h0);
      cyc(1'b0, 8'h00, 1'b0);
      chk("release csb", 80'({CHIP_SELECT_BAR, PLAIN_TEXT}),
          80'({1'b1, 64'h1111111111111111}));
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         chk("single issue", 80'({CHIP_SELECT_BAR, RecvLED}), 80'h0);
      end

      // ---- strobe on the expiry edge ----
      doReset();
      cyc(1'b1, 8'h51, 1'b0);
      cyc(1'b1, 8'h52, 1'b0);
      for (int k = 0; k < TO - 1; k++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h53, 1'b0);
      chk("expiry strobe", 80'({TIMEOUT_ERR, BYTE_CNT}), 80'({1'b0, 4'd3}));
      for (int k = 0; k < TO - 1; k++) cyc(1'b0, 8'h00, 1'b0);
      chk("restart no to", 80'({TIMEOUT_ERR, BYTE_CNT}), 80'({1'b0, 4'd3}));
      cyc(1'b0, 8'h00, 1'b0);
      chk("restart to", 80'({TIMEOUT_ERR, BYTE_CNT}), 80'({1'b1, 4'd0}));

      // ---- asynchronous reset mid-block ----
      doReset();
      for (int k = 0; k < 5; k++) cyc(1'b1, 8'h60 + 8'(k), 1'b0);
      chk("mid block cnt", 80'(BYTE_CNT), 80'd5);
      #2 RST_N = 1'b0;
      #1;
      chk("async rst block", outs(), 80'h0);
      #4 RST_N = 1'b1;
      for (int k = 0; k < TO + 4; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         if (outs() !== 80'h0) chk("quiet after rst", outs(), 80'h0);
      end
      chk("quiet end", outs(), 80'h0);

      // ---- asynchronous reset mid-pending ----
      sendBlock(64'h0F0E0D0C0B0A0908, 1'b1, 1'b1);
      chk("pending led", 80'({RecvLED, CHIP_SELECT_BAR}), 80'({1'b1, 1'b0}));
      #2 RST_N = 1'b0;
      #1;
      chk("async rst pend", outs(), 80'h0);
      #4 RST_N = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         chk("no issue after rst", outs(), 80'h0);
      end

`ifdef UART_RX_CHECKSUM_EN
      // ---- bad checksum ----
      doReset();
      sendBlock(64'h0807060504030201, 1'b0, 1'b0);
      chk("cs err", 80'({CHECKSUM_ERR, OVERRUN_ERR, BYTE_CNT, RecvLED}),
          80'({1'b1, 1'b0, 4'd0, 1'b0}));
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         chk("cs drop", 80'({CHECKSUM_ERR, CHIP_SELECT_BAR, PLAIN_TEXT}), 80'h0);
      end
`endif

      // ---- randomized traffic against the model ----
      doReset();
      modelReset();
      for (int c = 0; c < 3000; c++) begin
         case ((c / 300) % 3)
            0: pr = 70;
            1: pr = 25;
            default: pr = 2;
         endcase
         case ((c / 500) % 3)
            0: pb = 0;
            1: pb = 50;
            default: pb = 95;
         endcase
         r = ($urandom_range(0, 99) < pr);
         b = ($urandom_range(0, 99) < pb);
         d = 8'($urandom);
`ifdef UART_RX_CHECKSUM_EN
         if (r && part.size() == 8 && $urandom_range(0, 3) != 0) begin
            d = 8'h00;
            foreach (part[i]) d ^= part[i];
         end
`endif
         modelStep(r, d, b);
         cyc(r, d, b);
         chk("random", outs(), modelOuts());
      end

      $display("[TB] %0d tests run, %0d failed", nRun, nFail);
      $finish;
   end

endmodule
